pma_seq_region_checker: RTL and testbench
=========================================

Name: pma_seq_region_checker

Overview:
- Sequential physical-memory-attribute lookup engine for the CVA6 config region tables: execute, cached and non-idempotent base/length rules.
- Reports executable/cacheable/non-idempotent attributes for one physical address per request.
- Scans one rule index per cycle, trading combinational comparators for latency.
- Used by slow-path consumers (debug/discovery, PTW attribute checks), not the fetch/LSU critical path.

Parameters:
- AddrWidth, 64, physical address width; also the width of each base and length field.
- NrExecRules, 3, number of valid execute-region rules (0..16).
- NrCachedRules, 1, number of valid cached-region rules (0..16).
- NrNonIdemRules, 2, number of valid non-idempotent rules (0..16).
- ExecBase / ExecLength, 1024-bit, 16 packed 64-bit fields; rule i at bits [64*i+63:64*i]. Default base {0x8000_0000, 0x1_0000, 0x0}, length {0x4000_0000, 0x10000, 0x1000} (index 0 = base 0x0).
- CachedBase / CachedLength, 1024-bit, default rule 0 = 0x8000_0000 / 0x4000_0000.
- NonIdemBase / NonIdemLength, 1024-bit, default all zero.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  abort any in-flight lookup
- req_valid_i  in  1  lookup request valid
- req_ready_o  out  1  engine can accept a request
- addr_i  in  AddrWidth  physical address to classify
- resp_valid_o  out  1  result valid
- resp_ready_i  in  1  consumer accepts result
- executable_o  out  1  addr falls in an execute region
- cacheable_o  out  1  addr falls in a cached region
- nonidempotent_o  out  1  addr falls in a non-idempotent region

Behaviour:
- MaxN = max(NrExecRules, NrCachedRules, NrNonIdemRules). Index counter width = $clog2(MaxN+1), minimum 1.
- FSM states: IDLE, SCAN, RESP.
- Reset (asynchronous, rst_ni=0):
  - state=IDLE, idx=0, latched addr=0, all attribute flags=0, resp_valid_o=0.
  - req_ready_o=1 (combinational from IDLE).
- IDLE:
  - req_ready_o=1; resp_valid_o=0.
  - On req_valid_i && req_ready_o: latch addr_i, clear flags, idx=0.
  - Next state is SCAN, or RESP directly if MaxN==0.
- SCAN, cycle with index i:
  - For each table t with i < N_t: flag_t |= match(addr, base_t[i], len_t[i]).
  - If i==MaxN-1, go to RESP; else idx++.
- Match rule: len!=0 && addr >= base && {1'b0,addr} < {1'b0,base}+{1'b0,len}.
  - The sum is computed in AddrWidth+1 bits, so there is no wrap; the upper bound is exclusive.
- RESP:
  - resp_valid_o=1; attribute outputs driven from the flag registers and held stable while resp_ready_i=0.
  - On resp_ready_i: go to IDLE. The next request is acceptable the following cycle (no same-cycle bypass).
- Outputs are valid only while resp_valid_o=1. They are registered with no combinational path from addr_i.
- Latency: request handshake in cycle T -> resp_valid_o first high in cycle T+MaxN+1 (T+4 with defaults).
- req_ready_o=0 in SCAN and RESP; req_valid_i is ignored there.
- flush_i (any state): next cycle state=IDLE, resp_valid_o=0, flags cleared. A result pending in RESP is dropped.
  - flush_i has priority over a simultaneous request accept or response handshake. A request presented with flush_i is not accepted.
- Overlapping rules within or across tables: flags OR-accumulate, so multiple attributes may be set.
- Reset mid-scan returns to the IDLE reset state immediately; no partial response is ever issued.

Test Plan:
- Default params, addr 0x8000_1000, handshake at T -> resp_valid_o at T+4; exec=1, cache=1, nonidem=0.
- Boundaries:
  - addr 0xC000_0000 -> all 0.
  - addr 0xFFF -> exec=1, cache=0.
  - addr 0x1000 -> exec=0.
  - addr 0x1_FFFF -> exec=1.
- resp_ready_i held low 5 cycles after resp_valid_o -> outputs stable, req_ready_o=0 throughout. Handshake at cycle R -> req_ready_o=1 at R+1; a second request is accepted at R+1.
- flush_i pulsed at T+2 during SCAN -> no resp_valid_o, req_ready_o=1 at T+3. flush_i asserted with resp_valid_o high -> response dropped next cycle.
- Override CachedBase rule 0 = 0xFFFF_FFFF_FFFF_F000 with length 0x2000 -> addr 0xFFFF_FFFF_FFFF_FFFF gives cache=1 (no overflow wrap). Length 0 rule never matches, including addr == base.
- rst_ni asserted at T+2 mid-scan -> resp_valid_o=0 and req_ready_o=1 immediately. The first request after release completes normally with correct attributes.

Source files
------------

// File: rtl/pma_seq_region_checker_if.sv
// Request/response bundle for the sequential PMA region checker.
// The engine side uses the slave modport, the requester uses the master modport.
interface pma_seq_region_checker_if #(
    parameter int AddrWidth = 64
);
    logic                 flush_i;
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [AddrWidth-1:0] addr_i;
    logic                 resp_valid_o;
    logic                 resp_ready_i;
    logic                 executable_o;
    logic                 cacheable_o;
    logic                 nonidempotent_o;

    modport master (
        output flush_i,
        output req_valid_i,
        output addr_i,
        output resp_ready_i,
        input  req_ready_o,
        input  resp_valid_o,
        input  executable_o,
        input  cacheable_o,
        input  nonidempotent_o
    );

    modport slave (
        input  flush_i,
        input  req_valid_i,
        input  addr_i,
        input  resp_ready_i,
        output req_ready_o,
        output resp_valid_o,
        output executable_o,
        output cacheable_o,
        output nonidempotent_o
    );
endinterface

// File: rtl/pma_seq_region_checker.sv
// Sequential physical-memory-attribute lookup engine.
// One rule index is examined per cycle across the execute, cached and
// non-idempotent tables; matches OR-accumulate into registered flags that are
// presented once the last index has been scanned.
module pma_seq_region_checker #(
    parameter int             AddrWidth      = 64,
    parameter int             NrExecRules    = 3,
    parameter int             NrCachedRules  = 1,
    parameter int             NrNonIdemRules = 2,
    parameter logic [1023:0]  ExecBase       = {832'h0, 64'h8000_0000, 64'h1_0000, 64'h0},
    parameter logic [1023:0]  ExecLength     = {832'h0, 64'h4000_0000, 64'h1_0000, 64'h1000},
    parameter logic [1023:0]  CachedBase     = {960'h0, 64'h8000_0000},
    parameter logic [1023:0]  CachedLength   = {960'h0, 64'h4000_0000},
    parameter logic [1023:0]  NonIdemBase    = 1024'h0,
    parameter logic [1023:0]  NonIdemLength  = 1024'h0
) (
    input logic                     clk_i,
    input logic                     rst_ni,
    pma_seq_region_checker_if.slave bus
);

    localparam int MaxEc = (NrExecRules > NrCachedRules) ? NrExecRules : NrCachedRules;
    localparam int MaxN  = (MaxEc > NrNonIdemRules) ? MaxEc : NrNonIdemRules;
    localparam int IdxW  = (MaxN > 0) ? $clog2(MaxN + 1) : 1;

    localparam logic [IdxW-1:0] LastIdx      = (MaxN > 0) ? IdxW'(MaxN - 1) : '0;
    localparam logic [IdxW-1:0] ExecLimit    = IdxW'(NrExecRules);
    localparam logic [IdxW-1:0] CachedLimit  = IdxW'(NrCachedRules);
    localparam logic [IdxW-1:0] NonIdemLimit = IdxW'(NrNonIdemRules);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        RESP
    } state_e;

    state_e               state_q, state_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic                 exec_q, exec_d;
    logic                 cache_q, cache_d;
    logic                 nonidem_q, nonidem_d;

    logic [3:0]           rule_sel;
    logic [9:0]           bit_off;
    logic                 exec_hit;
    logic                 cache_hit;
    logic                 nonidem_hit;

    // The upper bound is formed one bit wider so a region ending at the top of
    // the address space does not wrap; a zero-length rule never matches.
    function automatic logic region_match(
        input logic [AddrWidth-1:0] a,
        input logic [AddrWidth-1:0] base,
        input logic [AddrWidth-1:0] len
    );
        logic [AddrWidth:0] upper;
        upper = {1'b0, base} + {1'b0, len};
        return (len != '0) && (a >= base) && ({1'b0, a} < upper);
    endfunction

    assign rule_sel = 4'(idx_q);
    assign bit_off  = {rule_sel, 6'd0};

    // Evaluate the single rule selected by the scan index in every table.
    always_comb begin
        exec_hit    = (idx_q < ExecLimit) &&
                      region_match(addr_q, ExecBase[bit_off +: AddrWidth], ExecLength[bit_off +: AddrWidth]);
        cache_hit   = (idx_q < CachedLimit) &&
                      region_match(addr_q, CachedBase[bit_off +: AddrWidth], CachedLength[bit_off +: AddrWidth]);
        nonidem_hit = (idx_q < NonIdemLimit) &&
                      region_match(addr_q, NonIdemBase[bit_off +: AddrWidth], NonIdemLength[bit_off +: AddrWidth]);
    end

    // Next-state logic; flush overrides any accept or response handshake.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        exec_d    = exec_q;
        cache_d   = cache_q;
        nonidem_d = nonidem_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    addr_d    = bus.addr_i;
                    idx_d     = '0;
                    exec_d    = 1'b0;
                    cache_d   = 1'b0;
                    nonidem_d = 1'b0;
                    state_d   = (MaxN == 0) ? RESP : SCAN;
                end
            end
            SCAN: begin
                exec_d    = exec_q | exec_hit;
                cache_d   = cache_q | cache_hit;
                nonidem_d = nonidem_q | nonidem_hit;
                if (idx_q == LastIdx) begin
                    state_d = RESP;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            RESP: begin
                if (bus.resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.flush_i) begin
            state_d   = IDLE;
            idx_d     = '0;
            exec_d    = 1'b0;
            cache_d   = 1'b0;
            nonidem_d = 1'b0;
        end
    end

    // State, scan index, latched address and attribute flag registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            addr_q    <= '0;
            exec_q    <= 1'b0;
            cache_q   <= 1'b0;
            nonidem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            exec_q    <= exec_d;
            cache_q   <= cache_d;
            nonidem_q <= nonidem_d;
        end
    end

    assign bus.req_ready_o     = (state_q == IDLE);
    assign bus.resp_valid_o    = (state_q == RESP);
    assign bus.executable_o    = exec_q;
    assign bus.cacheable_o     = cache_q;
    assign bus.nonidempotent_o = nonidem_q;

endmodule

// File: tb/tb_pma_seq_region_checker.sv
// Bench for the sequential PMA region checker.
// Two instances share one stimulus stream: one with the default tables and one
// with an alternate cached/non-idempotent table (top-of-memory region,
// zero-length rule, overlapping non-idempotent rule). Expected attributes come
// from a rule-list model and are checked by a monitor through a scoreboard.
module tb_pma_seq_region_checker;

    localparam int MaxN = 3;

    localparam logic [1023:0] AltCachedBase   = {896'h0, 64'h5000, 64'hFFFF_FFFF_FFFF_F000};
    localparam logic [1023:0] AltCachedLength = {896'h0, 64'h0, 64'h2000};
    localparam logic [1023:0] AltNonIdemBase  = {896'h0, 64'h0, 64'h1_8000};
    localparam logic [1023:0] AltNonIdemLen   = {896'h0, 64'h0, 64'h1_0000};

    typedef struct {
        logic [63:0] base;
        logic [63:0] len;
    } rule_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic [63:0] addr;
    logic        resp_ready;

    int          checks;
    int          failures;

    rule_t       exec_rules[$];
    rule_t       cache_rules0[$];
    rule_t       cache_rules1[$];
    rule_t       nonidem_rules0[$];
    rule_t       nonidem_rules1[$];
    logic [5:0]  sb[$];
    logic [63:0] pool[$];
    logic [5:0]  mon_exp;

    pma_seq_region_checker_if #(.AddrWidth(64)) bus0 ();
    pma_seq_region_checker_if #(.AddrWidth(64)) bus1 ();

    assign bus0.flush_i      = flush;
    assign bus0.req_valid_i  = req_valid;
    assign bus0.addr_i       = addr;
    assign bus0.resp_ready_i = resp_ready;
    assign bus1.flush_i      = flush;
    assign bus1.req_valid_i  = req_valid;
    assign bus1.addr_i       = addr;
    assign bus1.resp_ready_i = resp_ready;

    pma_seq_region_checker dut0 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus0)
    );

    pma_seq_region_checker #(
        .NrCachedRules (2),
        .CachedBase    (AltCachedBase),
        .CachedLength  (AltCachedLength),
        .NonIdemBase   (AltNonIdemBase),
        .NonIdemLength (AltNonIdemLen)
    ) dut1 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus1)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Address is inside a rule when its offset from the base is below the length.
    function automatic bit hits(input logic [63:0] a, input rule_t rules[$]);
        foreach (rules[i]) begin
            if (a >= rules[i].base && (a - rules[i].base) < rules[i].len) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Expected {exec,cache,nonidem} for instance 0 followed by instance 1.
    function automatic logic [5:0] expect_for(input logic [63:0] a);
        return {hits(a, exec_rules), hits(a, cache_rules0), hits(a, nonidem_rules0),
                hits(a, exec_rules), hits(a, cache_rules1), hits(a, nonidem_rules1)};
    endfunction

    function automatic logic [5:0] outputs_now();
        return {bus0.executable_o, bus0.cacheable_o, bus0.nonidempotent_o,
                bus1.executable_o, bus1.cacheable_o, bus1.nonidempotent_o};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: every response handshake pops one expected entry.
    always @(negedge clk) begin
        if (rst_n && bus0.resp_valid_o && resp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_resp: got a response, expected none");
            end else begin
                mon_exp = sb.pop_front();
                checkOutput("resp_attrs", {57'h0, bus1.resp_valid_o, outputs_now()}, {57'h0, 1'b1, mon_exp});
            end
        end
    end

    // Present one request; it must be accepted on the first cycle the bench tries.
    task automatic issueRequest(input logic [63:0] a);
        int wait_cnt;
        wait_cnt = 0;
        @(negedge clk);
        while (!bus0.req_ready_o && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        checkOutput("accept_wait", 64'(wait_cnt), 64'd0);
        req_valid = 1'b1;
        addr      = a;
        sb.push_back(expect_for(a));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Full transaction: latency check, optional back-pressure, then handshake.
    task automatic applyStimulus(input logic [63:0] a, input int hold);
        int         edges;
        logic [5:0] captured;
        issueRequest(a);
        edges = 1;
        @(negedge clk);
        while (!bus0.resp_valid_o && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        checkOutput("latency", 64'(edges), 64'(MaxN + 1));
        if (!bus0.resp_valid_o) begin
            sb.delete();
            return;
        end
        captured = outputs_now();
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checkOutput("hold_stable", {56'h0, bus0.resp_valid_o, bus0.req_ready_o, outputs_now()},
                        {56'h0, 1'b1, 1'b0, captured});
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        checkOutput("ready_after_resp", {62'h0, bus0.req_ready_o, bus0.resp_valid_o}, 64'b10);
    endtask

    // Stop a run that would otherwise never finish.
    initial begin
        #500000;
        failures++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Main stimulus sequence.
    initial begin
        int          wc;
        logic [63:0] a;
        logic [63:0] off;

        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        flush      = 1'b0;
        req_valid  = 1'b0;
        addr       = '0;
        resp_ready = 1'b0;

        exec_rules.push_back('{64'h0, 64'h1000});
        exec_rules.push_back('{64'h1_0000, 64'h1_0000});
        exec_rules.push_back('{64'h8000_0000, 64'h4000_0000});
        cache_rules0.push_back('{64'h8000_0000, 64'h4000_0000});
        cache_rules1.push_back('{64'hFFFF_FFFF_FFFF_F000, 64'h2000});
        cache_rules1.push_back('{64'h5000, 64'h0});
        nonidem_rules0.push_back('{64'h0, 64'h0});
        nonidem_rules0.push_back('{64'h0, 64'h0});
        nonidem_rules1.push_back('{64'h1_8000, 64'h1_0000});
        nonidem_rules1.push_back('{64'h0, 64'h0});

        pool = '{64'h0, 64'hFFF, 64'h1000, 64'hFFFF, 64'h1_0000, 64'h1_7FFF, 64'h1_8000,
                 64'h1_FFFF, 64'h2_0000, 64'h2_7FFF, 64'h2_8000, 64'h5000, 64'h7FFF_FFFF,
                 64'h8000_0000, 64'hBFFF_FFFF, 64'hC000_0000, 64'hFFFF_FFFF_FFFF_EFFF,
                 64'hFFFF_FFFF_FFFF_F000, 64'hFFFF_FFFF_FFFF_FFFF};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_state", {56'h0, bus0.req_ready_o, bus0.resp_valid_o, outputs_now()}, {56'h0, 2'b10, 6'b0});
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(64'h8000_1000, 0);
        applyStimulus(64'hC000_0000, 0);
        applyStimulus(64'hFFF, 0);
        applyStimulus(64'h1000, 0);
        applyStimulus(64'h1_FFFF, 0);
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 0);
        applyStimulus(64'h5000, 0);
        applyStimulus(64'h1_8000, 0);
        applyStimulus(64'h8000_0000, 5);
        applyStimulus(64'h0, 0);

        issueRequest(64'h8000_1000);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        sb.delete();
        checkOutput("flush_scan", {62'h0, bus0.resp_valid_o, bus0.req_ready_o}, 64'b01);
        resp_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        resp_ready = 1'b0;
        checkOutput("flush_scan_quiet", {62'h0, bus0.resp_valid_o, bus1.resp_valid_o}, 64'b00);

        issueRequest(64'hFFF);
        wc = 0;
        @(negedge clk);
        while (!bus0.resp_valid_o && wc < 20) begin
            @(negedge clk);
            wc++;
        end
        checkOutput("flush_resp_seen", {63'h0, bus0.resp_valid_o}, 64'b1);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        sb.delete();
        checkOutput("flush_drops_resp", {61'h0, bus0.resp_valid_o, bus1.resp_valid_o, bus0.req_ready_o}, 64'b001);

        @(negedge clk);
        flush     = 1'b1;
        req_valid = 1'b1;
        addr      = 64'h8000_1000;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        checkOutput("flush_blocks_accept", {63'h0, bus0.req_ready_o}, 64'b1);

        issueRequest(64'h1_0000);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        sb.delete();
        checkOutput("reset_mid_scan", {56'h0, bus0.resp_valid_o, bus0.req_ready_o, outputs_now()}, {56'h0, 2'b01, 6'b0});
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(64'h8000_1000, 1);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 2))
                0: a = pool[$urandom_range(0, pool.size() - 1)];
                1: begin
                    off = 64'($urandom_range(0, 4));
                    a   = pool[$urandom_range(0, pool.size() - 1)] + off - 64'd2;
                end
                default: a = {$urandom, $urandom};
            endcase
            applyStimulus(a, $urandom_range(0, 3));
        end

        repeat (2) @(posedge clk);
        checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
